// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_MEM   = 2'd2,
        ST_FLUSH = 2'd3
    } pipe_state_t;

    localparam int PERF_CNT_W       = 16;
    localparam int FLUSH_CYCLES_DEF = 1;
    localparam int MAX_STALL_DEF    = 15;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the performance counters.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: memory wait, branch flush, RAW hazard stall with watchdog.
// Define STALL_PERF_CNT_EN to build the stall_cycles / flush_count performance counters.
//
// state | meaning
// RUN   | pipeline flowing, no control asserted
// HAZ   | RAW hazard stall: front end frozen, bubble into ID/EXE
// MEM   | data memory busy: whole pipe frozen, flush/stall progress held
// FLUSH | post-branch flush cycles still owed (flush_rem_q > 0)
module pipeline_stall_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int MAX_STALL    = MAX_STALL_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hazard_detected,
    input  logic                  branch_taken,
    input  logic                  mem_ready,
    output logic                  freeze_if,
    output logic                  freeze_id,
    output logic                  freeze_exe_mem,
    output logic                  bubble_id_exe,
    output logic                  flush_if_id,
    output logic                  stall_timeout,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count
);

    localparam logic [1:0] FLUSH_REM_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] STALL_MAX      = 8'(MAX_STALL);
    localparam logic [7:0] STALL_TRIP     = 8'(MAX_STALL - 1);

    pipe_state_t state_q, state_d;
    logic [1:0]  flush_rem_q, flush_rem_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic        timeout_q, timeout_d;
    logic        flush_active;
    logic        f_if, f_id, f_em, bub, fl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_rem_q <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_rem_q <= flush_rem_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // A flush interrupted by a memory wait resumes from MEM with its remaining count.
    assign flush_active = (state_q == ST_FLUSH) ||
                          ((state_q == ST_MEM) && (flush_rem_q != 2'd0));

    always_comb begin
        state_d     = state_q;
        flush_rem_d = flush_rem_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = timeout_q;
        f_if        = 1'b0;
        f_id        = 1'b0;
        f_em        = 1'b0;
        bub         = 1'b0;
        fl          = 1'b0;
        if (!mem_ready) begin
            f_if    = 1'b1;
            f_id    = 1'b1;
            f_em    = 1'b1;
            state_d = ST_MEM;
        end else begin
            if (!hazard_detected) begin
                stall_cnt_d = '0;
            end
            if (branch_taken) begin
                fl          = 1'b1;
                bub         = 1'b1;
                flush_rem_d = FLUSH_REM_INIT;
                state_d     = (FLUSH_REM_INIT != 2'd0) ? ST_FLUSH : ST_RUN;
            end else if (flush_active) begin
                fl          = 1'b1;
                bub         = 1'b1;
                flush_rem_d = flush_rem_q - 2'd1;
                state_d     = (flush_rem_q == 2'd1) ? ST_RUN : ST_FLUSH;
            end else if (hazard_detected) begin
                f_if    = 1'b1;
                f_id    = 1'b1;
                bub     = 1'b1;
                state_d = ST_HAZ;
                if (stall_cnt_q != STALL_MAX) begin
                    stall_cnt_d = stall_cnt_q + 8'd1;
                end
                if (stall_cnt_q >= STALL_TRIP) begin
                    timeout_d = 1'b1;
                end
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    assign freeze_if      = f_if & ~rst;
    assign freeze_id      = f_id & ~rst;
    assign freeze_exe_mem = f_em & ~rst;
    assign bubble_id_exe  = bub  & ~rst;
    assign flush_if_id    = fl   & ~rst;
    assign stall_timeout  = timeout_q;

`ifdef STALL_PERF_CNT_EN
    logic branch_acc;
    assign branch_acc = branch_taken & mem_ready & ~rst;

    sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_perf (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_if),
        .clear (1'b0),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_perf (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_acc),
        .clear (1'b0),
        .count (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed plus randomized bench for pipeline_stall_ctrl against a priority-rule reference model.
module tb_pipeline_stall_ctrl;

    localparam int FC = 2;
    localparam int MS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_detected, branch_taken, mem_ready;
    logic        freeze_if, freeze_id, freeze_exe_mem, bubble_id_exe, flush_if_id, stall_timeout;
    logic [15:0] stall_cycles, flush_count;

    int tests = 0;
    int fails = 0;

    // reference model state
    int m_flush_left = 0;
    int m_streak     = 0;
    bit m_timeout    = 0;
    int m_stall_perf = 0;
    int m_flush_perf = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.FLUSH_CYCLES(FC), .MAX_STALL(MS)) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_ready       (mem_ready),
        .freeze_if       (freeze_if),
        .freeze_id       (freeze_id),
        .freeze_exe_mem  (freeze_exe_mem),
        .bubble_id_exe   (bubble_id_exe),
        .flush_if_id     (flush_if_id),
        .stall_timeout   (stall_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] perf_exp(input int v);
`ifdef STALL_PERF_CNT_EN
        return (v > 16'hFFFF) ? 16'hFFFF : 16'(v);
`else
        return 16'(v * 0);
`endif
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_streak     = 0;
        m_timeout    = 0;
        m_stall_perf = 0;
        m_flush_perf = 0;
    endtask

    task automatic step(input string tag, input logic h, input logic b, input logic m);
        logic e_fi, e_fd, e_fem, e_bub, e_fl;
        @(negedge clk);
        hazard_detected = h;
        branch_taken    = b;
        mem_ready       = m;
        #1;
        e_fi = 0; e_fd = 0; e_fem = 0; e_bub = 0; e_fl = 0;
        if (!m) begin
            e_fi = 1; e_fd = 1; e_fem = 1;
        end else if (b || m_flush_left > 0) begin
            e_fl = 1; e_bub = 1;
        end else if (h) begin
            e_fi = 1; e_fd = 1; e_bub = 1;
        end
        chk({tag, ".freeze_if"},      16'(freeze_if),      16'(e_fi));
        chk({tag, ".freeze_id"},      16'(freeze_id),      16'(e_fd));
        chk({tag, ".freeze_exe_mem"}, 16'(freeze_exe_mem), 16'(e_fem));
        chk({tag, ".bubble_id_exe"},  16'(bubble_id_exe),  16'(e_bub));
        chk({tag, ".flush_if_id"},    16'(flush_if_id),    16'(e_fl));
        chk({tag, ".stall_timeout"},  16'(stall_timeout),  16'(m_timeout));
        chk({tag, ".stall_cycles"},   stall_cycles,        perf_exp(m_stall_perf));
        chk({tag, ".flush_count"},    flush_count,         perf_exp(m_flush_perf));
        // advance the model to what the next clock edge should produce
        if (e_fi) m_stall_perf++;
        if (m) begin
            if (!h) m_streak = 0;
            if (b) begin
                m_flush_left = FC - 1;
                m_flush_perf++;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (h) begin
                m_streak++;
                if (m_streak >= MS) m_timeout = 1;
            end
        end
    endtask

    task automatic apply_reset(input string tag, input logic h, input logic b, input logic m);
        @(negedge clk);
        hazard_detected = h;
        branch_taken    = b;
        mem_ready       = m;
        rst             = 1'b1;
        #1;
        chk({tag, ".freeze_if"},      16'(freeze_if),      16'd0);
        chk({tag, ".freeze_id"},      16'(freeze_id),      16'd0);
        chk({tag, ".freeze_exe_mem"}, 16'(freeze_exe_mem), 16'd0);
        chk({tag, ".bubble_id_exe"},  16'(bubble_id_exe),  16'd0);
        chk({tag, ".flush_if_id"},    16'(flush_if_id),    16'd0);
        chk({tag, ".stall_timeout"},  16'(stall_timeout),  16'd0);
        chk({tag, ".stall_cycles"},   stall_cycles,        16'd0);
        chk({tag, ".flush_count"},    flush_count,         16'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hazard_detected = 1'b0;
        branch_taken    = 1'b0;
        mem_ready       = 1'b1;
        apply_reset("reset", 1'b1, 1'b1, 1'b0);

        // two-cycle RAW hazard
        step("haz1", 1, 0, 1);
        step("haz2", 1, 0, 1);
        step("haz_done", 0, 0, 1);

        // single taken branch flushes for FC cycles
        step("br", 0, 1, 1);
        step("br_fl2", 0, 0, 1);
        step("br_idle", 0, 0, 1);

        // memory wait in the middle of a flush resumes the remaining flush cycle
        step("br2", 0, 1, 1);
        step("memw1", 0, 0, 0);
        step("memw2", 1, 1, 0);
        step("memw3", 0, 0, 0);
        step("mem_resume", 0, 0, 1);
        step("mem_idle", 0, 0, 1);

        // hazard and branch together: branch wins
        step("haz_br", 1, 1, 1);
        step("haz_br_fl", 1, 0, 1);
        step("haz_br_after", 0, 0, 1);

        // watchdog: six consecutive stall cycles, then hazard drops
        for (int i = 0; i < 6; i++) step("wd_haz", 1, 0, 1);
        step("wd_drop1", 0, 0, 1);
        step("wd_drop2", 0, 0, 1);
        step("wd_mem", 1, 0, 0);
        step("wd_haz_again", 1, 0, 1);
        apply_reset("rst_mid", 1'b1, 1'b0, 1'b1);
        step("post_rst", 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 logic'($urandom_range(0, 2) != 0),
                 logic'($urandom_range(0, 6) == 0),
                 logic'($urandom_range(0, 4) != 0));
        end
        apply_reset("rst_final", 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
